// File: rtl/cpu4_pkg.sv
// rtl/cpu4_pkg.sv - shared opcodes, ALU ops, FSM states and decode bundle for the 4-bit CPU
package cpu4_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_CMPI = 4'h3;
  localparam logic [3:0] OP_ROLI = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_JS   = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_CMP = 2'b00;
  localparam logic [1:0] ALU_ROL = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_OUTW,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    JC_ALWAYS,
    JC_Z,
    JC_C,
    JC_S
  } jcond_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       acc_we;
    logic       acc_from_imm;
    logic       flag_we;
    logic       clr_c;
    logic       is_jump;
    jcond_t     jump_cond;
    logic       is_out;
    logic       is_halt;
  } decode_t;

  function automatic logic [3:0] pc_inc(input logic [3:0] p);
    return p + 4'd1;
  endfunction

endpackage

// File: rtl/cpu4_decode.sv
// rtl/cpu4_decode.sv - combinational opcode decoder for the 4-bit CPU sequencer
module cpu4_decode
  import cpu4_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec              = '0;
    dec.alu_op       = ALU_ADD;
    dec.jump_cond    = JC_ALWAYS;
    case (opcode)
      OP_LDI: begin
        dec.acc_we       = 1'b1;
        dec.acc_from_imm = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_op  = ALU_ADD;
        dec.acc_we  = 1'b1;
        dec.flag_we = 1'b1;
      end
      OP_CMPI: begin
        dec.alu_op  = ALU_CMP;
        dec.flag_we = 1'b1;
      end
      OP_ROLI: begin
        // Rotation carries nothing meaningful out, so C is forced clear.
        dec.alu_op  = ALU_ROL;
        dec.acc_we  = 1'b1;
        dec.flag_we = 1'b1;
        dec.clr_c   = 1'b1;
      end
      OP_JMP: begin
        dec.is_jump   = 1'b1;
        dec.jump_cond = JC_ALWAYS;
      end
      OP_JZ: begin
        dec.is_jump   = 1'b1;
        dec.jump_cond = JC_Z;
      end
      OP_JC: begin
        dec.is_jump   = 1'b1;
        dec.jump_cond = JC_C;
      end
      OP_JS: begin
        dec.is_jump   = 1'b1;
        dec.jump_cond = JC_S;
      end
      OP_OUT:  dec.is_out  = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu4_sequencer.sv
// rtl/cpu4_sequencer.sv - fetch/decode/execute controller owning ACC, PC, IR and flags
module cpu4_sequencer #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_r,
  input  logic       alu_cf,
  input  logic       alu_sf,
  input  logic       alu_zf,
  output logic [3:0] acc,
  output logic       flag_c,
  output logic       flag_s,
  output logic       flag_z,
  output logic [3:0] pc,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       halted
);
  import cpu4_pkg::*;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] acc_q, acc_d;
  logic       c_q, c_d;
  logic       s_q, s_d;
  logic       z_q, z_d;
  logic [3:0] out_data_q, out_data_d;
  logic       jump_taken;
  decode_t    dec;

  cpu4_decode u_decode (
    .opcode (ir_q[7:4]),
    .dec    (dec)
  );

  assign rom_addr  = pc_q;
  assign alu_a     = acc_q;
  assign alu_b     = ir_q[3:0];
  assign acc       = acc_q;
  assign flag_c    = c_q;
  assign flag_s    = s_q;
  assign flag_z    = z_q;
  assign pc        = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == ST_OUTW);
  assign halted    = (state_q == ST_HALT);

  always_comb begin
    jump_taken = 1'b0;
    case (dec.jump_cond)
      JC_ALWAYS: jump_taken = dec.is_jump;
      JC_Z:      jump_taken = dec.is_jump & z_q;
      JC_C:      jump_taken = dec.is_jump & c_q;
      JC_S:      jump_taken = dec.is_jump & s_q;
      default:   jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    c_d        = c_q;
    s_d        = s_q;
    z_d        = z_q;
    out_data_d = out_data_q;
    alu_op     = ALU_ADD;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pc_d    = pc_inc(pc_q);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // The ROM registered the FETCH address, so its word is valid now.
        ir_d    = rom_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_op = dec.alu_op;
        if (dec.acc_we) acc_d = dec.acc_from_imm ? ir_q[3:0] : alu_r;
        if (dec.flag_we) begin
          c_d = dec.clr_c ? 1'b0 : alu_cf;
          s_d = alu_sf;
          z_d = alu_zf;
        end
        if (jump_taken) pc_d = ir_q[3:0];
        if (dec.is_out) begin
          out_data_d = acc_q;
          state_d    = ST_OUTW;
        end else if (dec.is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_OUTW: begin
        if (out_ready) state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 8'h00;
      acc_q      <= 4'h0;
      c_q        <= 1'b0;
      s_q        <= 1'b0;
      z_q        <= 1'b0;
      out_data_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      c_q        <= c_d;
      s_q        <= s_d;
      z_q        <= z_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_cpu4_sequencer.sv
// tb/tb_cpu4_sequencer.sv - scoreboard bench with ISA-level reference model for cpu4_sequencer
module tb_cpu4_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [3:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_cf, alu_sf, alu_zf;
  logic [3:0] acc, pc, out_data;
  logic       flag_c, flag_s, flag_z;
  logic       out_valid, halted;
  logic       out_ready = 1'b0;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] rom [16];
  int exp_q[$];
  int m_acc, m_c, m_s, m_z, m_pc;

  cpu4_sequencer #(.RESET_PC(4'h0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
    .acc(acc), .flag_c(flag_c), .flag_s(flag_s), .flag_z(flag_z),
    .pc(pc), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // External ALU: CMP carry is a borrow; ROL rotates by imm[1:0] and reports A[3] as carry.
  always_comb begin
    logic [7:0] rot;
    rot    = {alu_a, alu_a} << alu_b[1:0];
    alu_r  = alu_a + alu_b;
    alu_cf = ({1'b0, alu_a} + {1'b0, alu_b}) > 5'd15;
    case (alu_op)
      2'b00: begin alu_r = alu_a - alu_b; alu_cf = alu_a < alu_b; end
      2'b10: begin alu_r = rot[7:4];      alu_cf = alu_a[3];      end
      default: ;
    endcase
    alu_sf = alu_r[3];
    alu_zf = (alu_r == 4'h0);
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_run();
    int p, a, c, s, z, steps, op, imm, t;
    bit done;
    p = 0; a = 0; c = 0; s = 0; z = 0; steps = 0; done = 0;
    while (!done && steps < 64) begin
      op  = rom[p] >> 4;
      imm = rom[p] & 15;
      p   = (p + 1) % 16;
      steps++;
      case (op)
        1: a = imm;
        2: begin t = a + imm; c = (t > 15); a = t % 16; s = a / 8; z = (a == 0); end
        3: begin t = (a - imm + 16) % 16; c = (a < imm); s = t / 8; z = (t == 0); end
        4: begin t = imm % 4; a = ((a << t) | (a >> (4 - t))) & 15; c = 0; s = a / 8; z = (a == 0); end
        5: p = imm;
        6: if (z) p = imm;
        7: if (c) p = imm;
        8: if (s) p = imm;
        9: exp_q.push_back(a);
        15: done = 1;
        default: ;
      endcase
    end
    m_acc = a; m_c = c; m_s = s; m_z = z; m_pc = p;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic run_prog(input string nm, input bit rnd_ready, output int cycles);
    exp_q.delete();
    out_ready = 1'b0;
    do_reset();
    model_run();
    @(negedge clk);
    run = 1'b1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      run = 1'b0;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end while (!halted && cycles < 400);
    check({nm, "_halted"}, halted, 1);
    check({nm, "_acc"}, acc, m_acc);
    check({nm, "_flag_c"}, flag_c, m_c);
    check({nm, "_flag_s"}, flag_s, m_s);
    check({nm, "_flag_z"}, flag_z, m_z);
    check({nm, "_pc"}, pc, m_pc);
    check({nm, "_pending_outs"}, exp_q.size(), 0);
  endtask

  bit pend = 0;
  logic [3:0] hold;
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else if (out_valid) begin
      if (pend) check("out_data_stable", out_data, hold);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL out_transfer: got unexpected value %0d, expected none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        pend = 0;
      end else begin
        pend = 1;
        hold = out_data;
      end
    end else begin
      pend = 0;
    end
  end

  initial begin
    int cyc, wraps, prev_pc, waited, p0;
    clear_rom();
    #12;
    check("rst_pc", pc, 0);
    check("rst_acc", acc, 0);
    check("rst_flags", {flag_c, flag_s, flag_z}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_halted", halted, 0);
    check("rst_alu_op", alu_op, 3);
    check("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;

    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h90; rom[3] = 8'hF0;
    run_prog("basic", 1'b0, cyc);
    // One edge leaves IDLE, then 3+3+4+3 edges reach HALT.
    check("basic_cycles", cyc, 14);

    clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h75; rom[3] = 8'hF0;
    rom[4] = 8'hF0; rom[5] = 8'h90; rom[6] = 8'hF0;
    run_prog("overflow", 1'b0, cyc);

    clear_rom();
    rom[0] = 8'h17; rom[1] = 8'h37; rom[2] = 8'h64; rom[3] = 8'hF0;
    rom[4] = 8'h90; rom[5] = 8'hF0;
    run_prog("compare", 1'b0, cyc);

    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h41; rom[2] = 8'hF0;
    run_prog("rotate", 1'b0, cyc);

    clear_rom();
    rom[0] = 8'h16; rom[1] = 8'h90; rom[2] = 8'hF0;
    exp_q.delete();
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    run = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
      run = 1'b0;
    end while (!out_valid && waited < 50);
    check("bp_valid_seen", out_valid, 1);
    p0 = pc;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", out_valid, 1);
      check("bp_data", out_data, 6);
      check("bp_pc_frozen", pc, p0);
      @(posedge clk);
      #1;
    end
    check("bp_still_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("bp_rst_valid", out_valid, 0);
    check("bp_rst_pc", pc, 0);
    check("bp_rst_acc", acc, 0);
    #1;
    rst = 1'b0;

    clear_rom();
    do_reset();
    @(negedge clk);
    run = 1'b1;
    wraps = 0;
    prev_pc = pc;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      run = 1'b0;
      check("nop_alu_op_legal", int'(alu_op != 2'b01), 1);
      if (prev_pc == 15 && pc == 0) wraps++;
      prev_pc = pc;
    end
    check("nop_pc_wrapped", int'(wraps >= 1), 1);
    check("nop_not_halted", halted, 0);

    for (int n = 0; n < 20; n++) begin
      clear_rom();
      for (int a = 0; a < 15; a++) begin
        int op, imm;
        op  = $urandom_range(0, 15);
        imm = (op >= 5 && op <= 8) ? $urandom_range(a + 1, 15) : $urandom_range(0, 15);
        rom[a] = 8'((op << 4) | imm);
      end
      rom[15] = 8'hF0;
      run_prog("random", 1'b1, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
